// File: rtl/nbody_accel.sv
// nbody_accel: memory-mapped 2-D gravitational N-body accelerator, IEEE-754 double precision.
// Optional build macro NBODY_CYCLE_COUNT_EN adds a 64-bit busy-cycle counter readable at select 0x43.

module nbody_dly #(
    parameter int unsigned W   = 64,
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] pipe_q [LAT];

    always_ff @(posedge clk) begin
        pipe_q[0] <= d;
        for (int k = 1; k < int'(LAT); k++) pipe_q[k] <= pipe_q[k-1];
    end

    assign q = pipe_q[LAT-1];
endmodule

// Behavioural equivalents of the FP library cores: result computed once, then a fixed-latency pipe.
module fp_add #(parameter int unsigned LAT = 20) (
    input  logic        clk,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic [63:0] res_d;
    always_comb res_d = $realtobits($bitstoreal(a) + $bitstoreal(b));
    nbody_dly #(.W(64), .LAT(LAT)) u_pipe (.clk(clk), .d(res_d), .q(y));
endmodule

module fp_mult #(parameter int unsigned LAT = 11) (
    input  logic        clk,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    logic [63:0] res_d;
    always_comb res_d = $realtobits($bitstoreal(a) * $bitstoreal(b));
    nbody_dly #(.W(64), .LAT(LAT)) u_pipe (.clk(clk), .d(res_d), .q(y));
endmodule

module fp_invsqrt #(parameter int unsigned LAT = 27) (
    input  logic        clk,
    input  logic [63:0] a,
    output logic [63:0] y
);
    logic [63:0] res_d;
    always_comb res_d = $realtobits(1.0 / $sqrt($bitstoreal(a)));
    nbody_dly #(.W(64), .LAT(LAT)) u_pipe (.clk(clk), .d(res_d), .q(y));
endmodule

module nbody_accel #(
    parameter int unsigned MULT_TIME       = 11,
    parameter int unsigned ADD_TIME        = 20,
    parameter int unsigned INVSQRT_TIME    = 27,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned BODY_ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [63:0]           writedata,
    output logic [63:0]           readdata
);
    localparam int unsigned LATENCY = 2 * ADD_TIME + INVSQRT_TIME + 4 * MULT_TIME;
    localparam int unsigned NB      = 1 << BODY_ADDR_WIDTH;
    localparam int unsigned IW      = BODY_ADDR_WIDTH + 1;
    localparam int unsigned SW      = ADDR_WIDTH - BODY_ADDR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(LATENCY + ADD_TIME + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FORCE_ISSUE, S_FORCE_WAIT, S_ACCUM, S_STORE,
        S_UPDATE_V, S_UPDATE_X, S_STEP_END, S_FINISH
    } state_t;

    state_t                     state_q, state_d;
    logic   [IW-1:0]            i_q, i_d, j_q, j_d, n_q, n_d;
    logic   [CNT_W-1:0]         cnt_q, cnt_d;
    logic   [31:0]              steps_q, steps_d, gap_q, gap_d;
    logic   [63:0]              acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic   [63:0]              readdata_q, readdata_d;
    logic                       done_q, done_d;

    logic [63:0] x_mem [NB];
    logic [63:0] y_mem [NB];
    logic [63:0] m_mem [NB];
    logic [63:0] vx_mem [NB];
    logic [63:0] vy_mem [NB];
    logic [63:0] ax_mem [NB];
    logic [63:0] ay_mem [NB];

    logic [SW-1:0]              sel;
    logic [BODY_ADDR_WIDTH-1:0] idx, ii, jj;
    logic                       wr_en, rd_en, busy, go, host_we;
    logic                       store_we, v_we, xy_we;

    assign sel     = addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH];
    assign idx     = addr[BODY_ADDR_WIDTH-1:0];
    assign ii      = i_q[BODY_ADDR_WIDTH-1:0];
    assign jj      = j_q[BODY_ADDR_WIDTH-1:0];
    assign wr_en   = chipselect && write;
    assign rd_en   = chipselect && read && !write;
    assign busy    = (state_q != S_IDLE);
    assign go      = wr_en && (sel == SW'(8'h00)) && writedata[0];
    assign host_we = wr_en && !busy && (sel >= SW'(8'h03)) && (sel <= SW'(8'h07));

    // Pair force pipeline: operands held stable by i/j while exactly one pair is in flight.
    logic [63:0] dx, dy, dx2, dy2, r2, s, p, q, c, mj_d, dx_dl, dy_dl, fx_raw, fy_raw, fx, fy;
    logic        r2_zero, zero_dl;

    fp_add  #(.LAT(ADD_TIME))  u_dx  (.clk(clk), .a(x_mem[jj]), .b({~x_mem[ii][63], x_mem[ii][62:0]}), .y(dx));
    fp_add  #(.LAT(ADD_TIME))  u_dy  (.clk(clk), .a(y_mem[jj]), .b({~y_mem[ii][63], y_mem[ii][62:0]}), .y(dy));
    fp_mult #(.LAT(MULT_TIME)) u_dx2 (.clk(clk), .a(dx), .b(dx), .y(dx2));
    fp_mult #(.LAT(MULT_TIME)) u_dy2 (.clk(clk), .a(dy), .b(dy), .y(dy2));
    fp_add  #(.LAT(ADD_TIME))  u_r2  (.clk(clk), .a(dx2), .b(dy2), .y(r2));
    fp_invsqrt #(.LAT(INVSQRT_TIME)) u_s (.clk(clk), .a(r2), .y(s));
    nbody_dly #(.W(64), .LAT(2 * ADD_TIME + MULT_TIME + INVSQRT_TIME)) u_mj_dly
        (.clk(clk), .d(m_mem[jj]), .q(mj_d));
    fp_mult #(.LAT(MULT_TIME)) u_p   (.clk(clk), .a(mj_d), .b(s), .y(p));
    fp_mult #(.LAT(MULT_TIME)) u_q   (.clk(clk), .a(s), .b(s), .y(q));
    fp_mult #(.LAT(MULT_TIME)) u_c   (.clk(clk), .a(p), .b(q), .y(c));
    nbody_dly #(.W(128), .LAT(ADD_TIME + INVSQRT_TIME + 3 * MULT_TIME)) u_d_dly
        (.clk(clk), .d({dx, dy}), .q({dx_dl, dy_dl}));
    fp_mult #(.LAT(MULT_TIME)) u_fx  (.clk(clk), .a(c), .b(dx_dl), .y(fx_raw));
    fp_mult #(.LAT(MULT_TIME)) u_fy  (.clk(clk), .a(c), .b(dy_dl), .y(fy_raw));

    assign r2_zero = (r2[62:0] == 63'd0);
    nbody_dly #(.W(1), .LAT(INVSQRT_TIME + 3 * MULT_TIME)) u_z_dly (.clk(clk), .d(r2_zero), .q(zero_dl));
    assign fx = zero_dl ? 64'd0 : fx_raw;
    assign fy = zero_dl ? 64'd0 : fy_raw;

    // Shared adders: force accumulation, then velocity and position updates.
    logic [63:0] add_xa, add_xb, add_ya, add_yb, sum_x, sum_y;
    always_comb begin
        add_xa = acc_x_q;
        add_xb = fx;
        add_ya = acc_y_q;
        add_yb = fy;
        if (state_q == S_UPDATE_V) begin
            add_xa = vx_mem[ii];
            add_xb = ax_mem[ii];
            add_ya = vy_mem[ii];
            add_yb = ay_mem[ii];
        end else if (state_q == S_UPDATE_X) begin
            add_xa = x_mem[ii];
            add_xb = vx_mem[ii];
            add_ya = y_mem[ii];
            add_yb = vy_mem[ii];
        end
    end
    fp_add #(.LAT(ADD_TIME)) u_add_x (.clk(clk), .a(add_xa), .b(add_xb), .y(sum_x));
    fp_add #(.LAT(ADD_TIME)) u_add_y (.clk(clk), .a(add_ya), .b(add_yb), .y(sum_y));

`ifdef NBODY_CYCLE_COUNT_EN
    logic [63:0] cyc_q, cyc_d;
    always_comb begin
        cyc_d = cyc_q;
        if (!busy && go) cyc_d = 64'd0;
        else if (busy)   cyc_d = cyc_q + 64'd1;
    end
`endif

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        cnt_d    = cnt_q + CNT_W'(1);
        steps_d  = steps_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        done_d   = done_q;
        n_d      = n_q;
        gap_d    = gap_q;
        store_we = 1'b0;
        v_we     = 1'b0;
        xy_we    = 1'b0;

        if (wr_en && !busy && sel == SW'(8'h02))
            n_d = (writedata[IW-1:0] > IW'(NB)) ? IW'(NB) : writedata[IW-1:0];
        if (wr_en && !busy && sel == SW'(8'h08)) gap_d = writedata[31:0];
        if (wr_en && sel == SW'(8'h01) && writedata[0]) done_d = 1'b0;

        unique case (state_q)
            S_IDLE: if (go) begin
                done_d  = 1'b0;
                i_d     = '0;
                j_d     = '0;
                acc_x_d = 64'd0;
                acc_y_d = 64'd0;
                steps_d = gap_q;
                state_d = (gap_q == 32'd0 || n_q == '0) ? S_FINISH : S_FORCE_ISSUE;
            end
            S_FORCE_ISSUE: begin
                cnt_d = '0;
                if (j_q >= n_q)      state_d = S_STORE;
                else if (j_q == i_q) j_d = j_q + IW'(1);
                else                 state_d = S_FORCE_WAIT;
            end
            S_FORCE_WAIT: if (cnt_q == CNT_W'(LATENCY - 1)) begin
                cnt_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: if (cnt_q == CNT_W'(ADD_TIME)) begin
                acc_x_d = sum_x;
                acc_y_d = sum_y;
                j_d     = j_q + IW'(1);
                state_d = S_FORCE_ISSUE;
            end
            S_STORE: begin
                store_we = 1'b1;
                acc_x_d  = 64'd0;
                acc_y_d  = 64'd0;
                j_d      = '0;
                cnt_d    = '0;
                if (i_q + IW'(1) < n_q) begin
                    i_d     = i_q + IW'(1);
                    state_d = S_FORCE_ISSUE;
                end else begin
                    i_d     = '0;
                    state_d = S_UPDATE_V;
                end
            end
            S_UPDATE_V: if (cnt_q == CNT_W'(ADD_TIME)) begin
                v_we    = 1'b1;
                cnt_d   = '0;
                state_d = S_UPDATE_X;
            end
            S_UPDATE_X: if (cnt_q == CNT_W'(ADD_TIME)) begin
                xy_we = 1'b1;
                cnt_d = '0;
                if (i_q + IW'(1) < n_q) begin
                    i_d     = i_q + IW'(1);
                    state_d = S_UPDATE_V;
                end else begin
                    state_d = S_STEP_END;
                end
            end
            S_STEP_END: begin
                steps_d = steps_q - 32'd1;
                i_d     = '0;
                j_d     = '0;
                state_d = (steps_q == 32'd1) ? S_FINISH : S_FORCE_ISSUE;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read mux; a simultaneous write wins and leaves readdata untouched.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (sel)
                SW'(8'h40): readdata_d = {63'd0, done_q};
                SW'(8'h41): readdata_d = busy ? 64'd0 : x_mem[idx];
                SW'(8'h42): readdata_d = busy ? 64'd0 : y_mem[idx];
`ifdef NBODY_CYCLE_COUNT_EN
                SW'(8'h43): readdata_d = cyc_q;
`endif
                default:    readdata_d = 64'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            steps_q    <= 32'd0;
            gap_q      <= 32'd0;
            acc_x_q    <= 64'd0;
            acc_y_q    <= 64'd0;
            done_q     <= 1'b0;
            readdata_q <= 64'd0;
`ifdef NBODY_CYCLE_COUNT_EN
            cyc_q      <= 64'd0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            steps_q    <= steps_d;
            gap_q      <= gap_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
`ifdef NBODY_CYCLE_COUNT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    // Body memories are never cleared; host writes only land while idle.
    always_ff @(posedge clk) begin
        if (host_we) begin
            case (sel)
                SW'(8'h03): x_mem[idx]  <= writedata;
                SW'(8'h04): y_mem[idx]  <= writedata;
                SW'(8'h05): m_mem[idx]  <= writedata;
                SW'(8'h06): vx_mem[idx] <= writedata;
                default:    vy_mem[idx] <= writedata;
            endcase
        end
        if (store_we) begin
            ax_mem[ii] <= acc_x_q;
            ay_mem[ii] <= acc_y_q;
        end
        if (v_we) begin
            vx_mem[ii] <= sum_x;
            vy_mem[ii] <= sum_y;
        end
        if (xy_we) begin
            x_mem[ii] <= sum_x;
            y_mem[ii] <= sum_y;
        end
    end

    assign readdata = readdata_q;
endmodule

// File: tb/tb_nbody_accel.sv
// Directed testbench for nbody_accel: register access, physics results and run-control corner cases.
module tb_nbody_accel;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [63:0] writedata = 64'd0;
    logic [63:0] readdata;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] S_GO = 7'h00, S_RD = 7'h01, S_N = 7'h02, S_X = 7'h03, S_Y = 7'h04,
                           S_M = 7'h05, S_VX = 7'h06, S_VY = 7'h07, S_GAP = 7'h08,
                           S_DONE = 7'h40, S_RX = 7'h41, S_RY = 7'h42, S_CYC = 7'h43;

    nbody_accel dut (
        .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
        .addr(addr), .writedata(writedata), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [6:0] s, input logic [8:0] i, input logic [63:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; addr = {s, i}; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [6:0] s, input logic [8:0] i, output logic [63:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; addr = {s, i};
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic load_body(input int i, input real x, input real y, input real vx, input real vy, input real m);
        bus_write(S_X, 9'(i), $realtobits(x));
        bus_write(S_Y, 9'(i), $realtobits(y));
        bus_write(S_VX, 9'(i), $realtobits(vx));
        bus_write(S_VY, 9'(i), $realtobits(vy));
        bus_write(S_M, 9'(i), $realtobits(m));
    endtask

    task automatic wait_done(input string name);
        logic [63:0] d;
        int n;
        d = 64'd0;
        n = 0;
        while (d != 64'd1 && n < 3000) begin
            bus_read(S_DONE, 9'd0, d);
            n++;
        end
        checks++;
        if (d !== 64'd1) begin
            failures++;
            $display("FAIL %s done_timeout got=%h exp=1", name, d);
        end
    endtask

    // Acceleration contribution on body i from body j (d is the dx or dy component).
    function automatic real accel(input real mj, input real d, input real dx, input real dy);
        real r2, s;
        r2 = dx * dx + dy * dy;
        if (r2 == 0.0) return 0.0;
        s = 1.0 / $sqrt(r2);
        return ((mj * s) * (s * s)) * d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        do_reset();
        checks++;
        if (readdata !== 64'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        bus_read(S_DONE, 9'd0, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL reset_done got=%h exp=0", d); end
        bus_write(S_X, 9'd0, 64'h4014_0000_0000_0000);
        bus_read(S_RX, 9'd0, d);
        checks++;
        if (d !== 64'h4014_0000_0000_0000) begin failures++; $display("FAIL readback_x got=%h exp=4014000000000000", d); end
        bus_read(7'h10, 9'd0, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
`ifndef NBODY_CYCLE_COUNT_EN
        bus_read(S_CYC, 9'd0, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL cyc_disabled got=%h exp=0", d); end
`endif
    endtask

    task automatic test_single_body();
        logic [63:0] d, ex;
        load_body(0, 1.0, 10.0, 0.1, 0.0, 1000.0);
        bus_write(S_N, 9'd0, 64'd1);
        bus_write(S_GAP, 9'd0, 64'd2);
        bus_write(S_GO, 9'd0, 64'd1);
        wait_done("single");
        ex = $realtobits((1.0 + 0.1) + 0.1);
        bus_read(S_RX, 9'd0, d);
        checks++;
        if (d !== ex) begin failures++; $display("FAIL single_x got=%h exp=%h", d, ex); end
        bus_read(S_RY, 9'd0, d);
        checks++;
        if (d !== $realtobits(10.0)) begin failures++; $display("FAIL single_y got=%h exp=%h", d, $realtobits(10.0)); end
    endtask

    task automatic run_pair(input string name, input real m1);
        logic [63:0] d;
        logic [63:0] ex [4];
        load_body(0, 0.0, 0.0, 0.0, 0.0, 1.0);
        load_body(1, 3.0, 4.0, 0.0, 0.0, m1);
        bus_write(S_N, 9'd0, 64'd2);
        bus_write(S_GAP, 9'd0, 64'd1);
        bus_write(S_GO, 9'd0, 64'd1);
        wait_done(name);
        ex[0] = $realtobits(0.0 + (0.0 + (0.0 + accel(m1, 3.0, 3.0, 4.0))));
        ex[1] = $realtobits(0.0 + (0.0 + (0.0 + accel(m1, 4.0, 3.0, 4.0))));
        ex[2] = $realtobits(3.0 + (0.0 + (0.0 + accel(1.0, -3.0, -3.0, -4.0))));
        ex[3] = $realtobits(4.0 + (0.0 + (0.0 + accel(1.0, -4.0, -3.0, -4.0))));
        for (int k = 0; k < 4; k++) begin
            bus_read((k % 2 == 0) ? S_RX : S_RY, 9'(k / 2), d);
            checks++;
            if (d !== ex[k]) begin failures++; $display("FAIL %s_pos%0d got=%h exp=%h", name, k, d, ex[k]); end
        end
    endtask

    task automatic test_two_body();
        run_pair("two_body", 2.0);
    endtask

    task automatic test_zero_mass();
        run_pair("zero_mass", 0.0);
    endtask

    task automatic test_gap_zero();
        logic [63:0] d, ex;
        bus_write(S_GAP, 9'd0, 64'd0);
        bus_write(S_GO, 9'd0, 64'd1);
        bus_read(S_DONE, 9'd0, d);
        checks++;
        if (d !== 64'd1) begin failures++; $display("FAIL gap0_done got=%h exp=1", d); end
        ex = $realtobits(3.0 + (0.0 + (0.0 + accel(1.0, -3.0, -3.0, -4.0))));
        bus_read(S_RX, 9'd1, d);
        checks++;
        if (d !== ex) begin failures++; $display("FAIL gap0_unchanged got=%h exp=%h", d, ex); end
    endtask

    task automatic test_done_control();
        logic [63:0] d;
        bus_read(S_DONE, 9'd0, d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b1; addr = {S_GAP, 9'd0}; writedata = 64'd0;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        checks++;
        if (readdata !== 64'd1) begin failures++; $display("FAIL rw_hold got=%h exp=1", readdata); end
        bus_write(S_RD, 9'd0, 64'd1);
        bus_read(S_DONE, 9'd0, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL done_clear got=%h exp=0", d); end
    endtask

    task automatic test_busy();
        logic [63:0] d, ex;
        load_body(0, 0.0, 0.0, 0.0, 0.0, 1.0);
        load_body(1, 3.0, 4.0, 0.0, 0.0, 2.0);
        bus_write(S_GAP, 9'd0, 64'd1);
        bus_write(S_GO, 9'd0, 64'd1);
        bus_write(S_X, 9'd0, $realtobits(99.0));
        bus_read(S_RX, 9'd1, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL busy_read_x got=%h exp=0", d); end
        bus_read(S_DONE, 9'd0, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL busy_done got=%h exp=0", d); end
        wait_done("busy");
        ex = $realtobits(0.0 + (0.0 + (0.0 + accel(2.0, 3.0, 3.0, 4.0))));
        bus_read(S_RX, 9'd0, d);
        checks++;
        if (d !== ex) begin failures++; $display("FAIL busy_write_ignored got=%h exp=%h", d, ex); end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] d, ex;
        bus_read(S_RY, 9'd1, d);
        bus_write(S_GAP, 9'd0, 64'd3);
        bus_write(S_GO, 9'd0, 64'd1);
        repeat (40) @(negedge clk);
        do_reset();
        checks++;
        if (readdata !== 64'd0) begin failures++; $display("FAIL midrun_readdata got=%h exp=0", readdata); end
        bus_read(S_DONE, 9'd0, d);
        checks++;
        if (d !== 64'd0) begin failures++; $display("FAIL midrun_done got=%h exp=0", d); end
        load_body(0, 0.0, 0.0, 0.0, 0.0, 1.0);
        load_body(1, 3.0, 4.0, 0.0, 0.0, 2.0);
        bus_write(S_N, 9'd0, 64'd2);
        bus_write(S_GAP, 9'd0, 64'd1);
        bus_write(S_GO, 9'd0, 64'd1);
        wait_done("after_reset");
        ex = $realtobits(4.0 + (0.0 + (0.0 + accel(1.0, -4.0, -3.0, -4.0))));
        bus_read(S_RY, 9'd1, d);
        checks++;
        if (d !== ex) begin failures++; $display("FAIL after_reset_y1 got=%h exp=%h", d, ex); end
    endtask

    initial begin
        test_reset();
        test_single_body();
        test_two_body();
        test_zero_mass();
        test_gap_zero();
        test_done_control();
        test_busy();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
